// File: rtl/demux_stream.sv
// Two-way registered stream demultiplexer: each input beat is steered by selecter into one of
// two 2-entry port FIFOs, with per-port delivered-beat counters.
module demux_stream #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inputdata,
   input  logic             selecter,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] outputdata_0,
   output logic             out_valid_0,
   input  logic             out_ready_0,
   output logic [WIDTH-1:0] outputdata_1,
   output logic             out_valid_1,
   input  logic             out_ready_1,
   input  logic             clear_cnt,
   output logic [CNT_W-1:0] count_0,
   output logic [CNT_W-1:0] count_1
);

   // Storage is indexed [port][entry]
   logic [WIDTH-1:0] r_mem [2][2];
   logic [1:0]       r_wptr;
   logic [1:0]       r_rptr;
   logic [1:0]       r_occ [2];
   logic [CNT_W-1:0] r_cnt [2];

   logic w_full     [2];
   logic w_push     [2];
   logic w_pop      [2];
   logic w_out_rdy  [2];
   logic w_accept;

   assign w_out_rdy[0] = out_ready_0;
   assign w_out_rdy[1] = out_ready_1;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_full[p] = (r_occ[p] == 2'd2);
         w_pop[p]  = (r_occ[p] != 2'd0) && w_out_rdy[p];
      end
   end

   // Ready depends only on selecter and registered full flags, so a pop never
   // opens a same-cycle path into a full FIFO.
   assign in_ready  = selecter ? !w_full[1] : !w_full[0];
   assign w_accept  = in_valid && in_ready;
   assign w_push[0] = w_accept && !selecter;
   assign w_push[1] = w_accept && selecter;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= 2'b00;
         r_rptr <= 2'b00;
         for (int p = 0; p < 2; p++) begin
            r_occ[p]    <= 2'd0;
            r_cnt[p]    <= '0;
            r_mem[p][0] <= '0;
            r_mem[p][1] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
               r_mem[p][r_wptr[p]] <= inputdata;
               r_wptr[p]           <= ~r_wptr[p];
            end
            if (w_pop[p]) begin
               r_rptr[p] <= ~r_rptr[p];
            end
            case ({w_push[p], w_pop[p]})
               2'b10:   r_occ[p] <= r_occ[p] + 2'd1;
               2'b01:   r_occ[p] <= r_occ[p] - 2'd1;
               default: r_occ[p] <= r_occ[p];
            endcase
            if (clear_cnt) begin
               r_cnt[p] <= '0;
            end else if (w_pop[p]) begin
               r_cnt[p] <= r_cnt[p] + 1'b1;
            end
         end
      end
   end

   assign outputdata_0 = r_mem[0][r_rptr[0]];
   assign outputdata_1 = r_mem[1][r_rptr[1]];
   assign out_valid_0  = (r_occ[0] != 2'd0);
   assign out_valid_1  = (r_occ[1] != 2'd0);
   assign count_0      = r_cnt[0];
   assign count_1      = r_cnt[1];

endmodule

// File: tb/tb_demux_stream.sv
// Directed and randomized-streaming bench for demux_stream, built with CNT_W=4 so the
// counter wrap is reachable with a handful of beats.
module tb_demux_stream;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] inputdata;
   logic             selecter;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] outputdata_0;
   logic             out_valid_0;
   logic             out_ready_0;
   logic [WIDTH-1:0] outputdata_1;
   logic             out_valid_1;
   logic             out_ready_1;
   logic             clear_cnt;
   logic [CNT_W-1:0] count_0;
   logic [CNT_W-1:0] count_1;

   int n_cmp = 0;
   int n_err = 0;

   demux_stream #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inputdata    (inputdata),
      .selecter     (selecter),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .outputdata_0 (outputdata_0),
      .out_valid_0  (out_valid_0),
      .out_ready_0  (out_ready_0),
      .outputdata_1 (outputdata_1),
      .out_valid_1  (out_valid_1),
      .out_ready_1  (out_ready_1),
      .clear_cnt    (clear_cnt),
      .count_0      (count_0),
      .count_1      (count_1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic sel, input logic [31:0] data);
      in_valid  = 1'b1;
      selecter  = sel;
      inputdata = data;
   endtask

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          sent, tot0, tot1;
   logic        hold, pop0, pop1, acc, exp_rdy;

   initial begin
      rst_n = 1'b0; inputdata = '0; selecter = 1'b0; in_valid = 1'b0;
      out_ready_0 = 1'b0; out_ready_1 = 1'b0; clear_cnt = 1'b0;
      #12;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_valid0", out_valid_0, 0);
      check_eq("rst_valid1", out_valid_1, 0);
      check_eq("rst_data0", outputdata_0, 0);
      check_eq("rst_cnt0", count_0, 0);
      rst_n = 1'b1;
      tick();

      // Basic routing, both consumers ready
      out_ready_0 = 1'b1; out_ready_1 = 1'b1;
      offer(1'b0, 32'hDEADBEEF);
      #1 check_eq("br_in_ready", in_ready, 1);
      tick();
      check_eq("br_valid0", out_valid_0, 1);
      check_eq("br_data0", outputdata_0, 32'hDEADBEEF);
      offer(1'b1, 32'h12345678);
      tick();
      check_eq("br_cnt0", count_0, 1);
      check_eq("br_valid0_done", out_valid_0, 0);
      check_eq("br_valid1", out_valid_1, 1);
      check_eq("br_data1", outputdata_1, 32'h12345678);
      in_valid = 1'b0;
      tick();
      check_eq("br_cnt1", count_1, 1);
      check_eq("br_valid1_done", out_valid_1, 0);

      // Backpressure on port 0, port 1 keeps flowing
      out_ready_0 = 1'b0;
      offer(1'b0, 32'hA);
      #1 check_eq("bp_rdy_a", in_ready, 1);
      tick();
      offer(1'b0, 32'hB);
      #1 check_eq("bp_rdy_b", in_ready, 1);
      tick();
      offer(1'b1, 32'hF);
      #1 check_eq("bp_rdy_f", in_ready, 1);
      tick();
      offer(1'b0, 32'hC);
      #1 check_eq("bp_rdy_c_full", in_ready, 0);
      check_eq("bp_data1_f", outputdata_1, 32'hF);
      check_eq("bp_head_a", outputdata_0, 32'hA);
      tick();
      // Full FIFO popped this cycle: C must still be refused
      out_ready_0 = 1'b1;
      #1 check_eq("fp_rdy_same_cycle", in_ready, 0);
      check_eq("fp_cnt1", count_1, 2);
      tick();
      check_eq("fp_rdy_recover", in_ready, 1);
      check_eq("bp_head_b", outputdata_0, 32'hB);
      check_eq("bp_cnt0_a", count_0, 2);
      tick();
      in_valid = 1'b0;
      check_eq("bp_head_c", outputdata_0, 32'hC);
      check_eq("bp_valid_c", out_valid_0, 1);
      tick();
      check_eq("bp_drained", out_valid_0, 0);
      check_eq("bp_cnt0", count_0, 4);

      // Counter wrap and clear on port 1
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      check_eq("cc_cnt0_clr", count_0, 0);
      check_eq("cc_cnt1_clr", count_1, 0);
      for (int i = 0; i < 17; i++) begin
         offer(1'b1, 32'h100 + i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check_eq("cc_wrap", count_1, 1);
      offer(1'b1, 32'h55);
      tick();
      in_valid  = 1'b0;
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      check_eq("cc_clr_vs_inc", count_1, 0);
      check_eq("cc_delivered", out_valid_1, 0);

      // Reset with both FIFOs holding data and a nonzero counter
      offer(1'b0, 32'h77);
      tick();
      in_valid = 1'b0;
      tick();
      out_ready_0 = 1'b0; out_ready_1 = 1'b0;
      offer(1'b0, 32'h88);
      tick();
      offer(1'b1, 32'h99);
      tick();
      in_valid = 1'b0;
      check_eq("mr_pre_cnt0", count_0, 1);
      check_eq("mr_pre_valid1", out_valid_1, 1);
      rst_n = 1'b0;
      #1;
      check_eq("mr_valid0", out_valid_0, 0);
      check_eq("mr_valid1", out_valid_1, 0);
      check_eq("mr_cnt0", count_0, 0);
      check_eq("mr_in_ready", in_ready, 1);
      check_eq("mr_data1", outputdata_1, 0);
      tick();
      rst_n = 1'b1;
      out_ready_0 = 1'b1; out_ready_1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mr_stale0", out_valid_0, 0);
         check_eq("mr_stale1", out_valid_1, 0);
      end
      check_eq("mr_cnt_after", {count_1, count_0}, 0);

      // Random streaming against a queue model
      sent = 0; tot0 = 0; tot1 = 0; hold = 1'b0;
      for (int c = 0; c < 6000 && (sent < 1000 || q0.size() != 0 || q1.size() != 0); c++) begin
         if (sent >= 1000) begin
            in_valid = 1'b0;
            hold     = 1'b0;
         end else if (!hold) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            selecter  = 1'($urandom_range(0, 1));
            inputdata = $urandom;
         end
         out_ready_0 = 1'($urandom_range(0, 1));
         out_ready_1 = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = selecter ? (q1.size() < 2) : (q0.size() < 2);
         check_eq("s_in_ready", in_ready, exp_rdy);
         check_eq("s_valid0", out_valid_0, q0.size() != 0);
         check_eq("s_valid1", out_valid_1, q1.size() != 0);
         if (q0.size() != 0) check_eq("s_data0", outputdata_0, q0[0]);
         if (q1.size() != 0) check_eq("s_data1", outputdata_1, q1[0]);
         pop0 = (q0.size() != 0) && out_ready_0;
         pop1 = (q1.size() != 0) && out_ready_1;
         acc  = in_valid && exp_rdy;
         hold = in_valid && !exp_rdy;
         tick();
         if (pop0) begin void'(q0.pop_front()); tot0++; end
         if (pop1) begin void'(q1.pop_front()); tot1++; end
         if (acc) begin
            if (selecter) q1.push_back(inputdata);
            else          q0.push_back(inputdata);
            sent++;
         end
      end
      check_eq("s_sent", sent, 1000);
      check_eq("s_empty", q0.size() + q1.size(), 0);
      check_eq("s_total", tot0 + tot1, 1000);
      check_eq("s_cnt0", count_0, tot0 % 16);
      check_eq("s_cnt1", count_1, tot1 % 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/demux_stream.md
# demux_stream

Two-way registered demultiplexer for the datapath, the inverse of the existing 32-bit 2:1 mux: one input stream with a per-beat `selecter` is steered to one of two output streams. Each output has a 2-entry FIFO, so one stalled consumer does not block beats bound for the other port until that port's FIFO is full. Per-port delivered-beat counters support debug and bench checking.

## Interface
- `WIDTH`, default 32: data width of the input and both outputs.
- `CNT_W`, default 16: width of each delivered-beat counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `inputdata`  in  WIDTH  input beat data.
- `selecter`  in  1  destination of the current input beat: 0 routes to port 0, 1 routes to port 1.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  the beat can be accepted this cycle.
- `outputdata_0`  out  WIDTH  port 0 head data.
- `out_valid_0`  out  1  port 0 head valid.
- `out_ready_0`  in  1  port 0 consumer ready.
- `outputdata_1`  out  WIDTH  port 1 head data.
- `out_valid_1`  out  1  port 1 head valid.
- `out_ready_1`  in  1  port 1 consumer ready.
- `clear_cnt`  in  1  synchronous clear of both counters.
- `count_0`  out  CNT_W  number of beats delivered on port 0.
- `count_1`  out  CNT_W  number of beats delivered on port 1.

## Operation
- **Port FIFO:** each port p has a 2-entry FIFO with a write pointer, a read pointer and a 2-bit occupancy (0..2). `full_p` means occupancy == 2.
- **`in_ready` rule:** `in_ready = selecter ? !full_1 : !full_0`.
  - It is combinational from `selecter` and the registered full flags only.
  - It has no dependence on `in_valid` or on `out_ready_*`.
- **Accept:** a beat is accepted when `in_valid && in_ready`. It is pushed into the FIFO selected by `selecter`.
- **Deliver:** a beat is delivered on port p when `out_valid_p && out_ready_p`. The FIFO head is then popped.
- **Output signals:**
  - `out_valid_p` = occupancy_p != 0.
  - `outputdata_p` = FIFO head entry.
  - Both are driven directly from registers.
- **Full FIFO, simultaneous pop:** a push into a full FIFO is never accepted, even when that port pops in the same cycle. There is no fall-through path.
- **Push and pop together:** when occupancy is 1 and a push and a pop occur in the same cycle, occupancy stays 1, the head advances and the new beat becomes the head.
- **Ordering:** beats are kept in order within each port. No ordering exists between the two ports.
- **Stall rules:**
  - A stalled port blocks input only while `selecter` points at it and its FIFO is full.
  - Upstream must hold `inputdata`/`selecter` stable while `in_valid && !in_ready`. The block does not check this.
- **Counters:**
  - `count_p` increments by 1 on each delivery on port p and wraps from 2^CNT_W-1 to 0.
  - `clear_cnt` sets both counters to 0. It takes priority over a same-cycle increment, so the result is 0.
  - `clear_cnt` does not touch the FIFOs.
- **Pointers:** 1-bit pointers that wrap 1 -> 0.

## Timing
- **Reset (asynchronous assert, `rst_n` low):**
  - All FIFOs empty and pointers at 0.
  - `out_valid_0/1` = 0.
  - `outputdata_0/1` = 0, with FIFO storage cleared to 0.
  - `count_0/1` = 0.
  - `in_ready` = 1, since neither FIFO is full.
- **Reset release:** deassertion is sampled at the next rising edge. There are no reset-exit wait cycles.
- **Reset mid-operation:** all in-flight beats are discarded and nothing is delivered afterwards.
- **Latency:** a beat accepted at edge N makes `out_valid_p` = 1 with that data after edge N, so it is deliverable in cycle N+1. Minimum input-to-output latency is 1 cycle.
- **Throughput:**
  - One beat per cycle into either port while the consumer keeps `out_ready` high.
  - Occupancy toggles between 1 and 0/1 and never reaches full.
- **Backpressure:** with `out_ready_p` low, port p absorbs 2 beats. `in_ready` for that port drops on the cycle after the second push.
- **Recovery:** after a pop from a full FIFO, `in_ready` for that port returns to 1 on the next cycle.
- **Counter update:** `count_p` updates at the same edge as the delivery handshake.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-stream with both FIFOs holding data -> immediately `out_valid_0/1`=0, `count_0/1`=0, `in_ready`=1. After release nothing stale is delivered.
- **Basic routing:**
  - Stimulus: push 0xDEADBEEF with sel=0, then 0x12345678 with sel=1, both `out_ready` held high.
  - Required: port 0 delivers 0xDEADBEEF one cycle after accept, and port 1 delivers 0x12345678 one cycle after its accept.
  - Counters end at 1 and 1.
- **Backpressure:**
  - Stimulus: `out_ready_0`=0, then offer 0xA, 0xB, 0xC with sel=0.
  - Required: 0xA and 0xB accepted, `in_ready`=0 while 0xC is offered.
  - Meanwhile a beat 0xF with sel=1 is accepted.
  - Raising `out_ready_0` delivers 0xA, 0xB, 0xC in order, and 0xC is accepted one cycle after the first pop.
- **Full FIFO with simultaneous pop:** port 0 full and `out_ready_0`=1 in the same cycle as an offered sel=0 beat -> beat not accepted that cycle, accepted the next cycle.
- **Counter wrap and clear:**
  - With CNT_W=4, deliver 17 beats on port 1 -> `count_1`=1.
  - Assert `clear_cnt` in the same cycle as a delivery -> `count_1`=0.
- **Streaming:** 1000 random beats with random sel and random `out_ready` -> each port's output sequence equals its input-order subsequence, and the counters equal the per-port totals.
